// File: rtl/ifetch.sv
// Instruction fetch unit: walks the pc, fetches words from memory (or a direct-mapped
// icache when ICACHE_EN is defined) and pushes them to the instruction queue.
module ifetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iq_full,
    input  logic        jump_en,
    input  logic [31:0] jump_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] pc_out
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        inst_rdy_q, inst_rdy_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic        hit;
    logic [31:0] hit_data;
    logic [31:0] jump_tgt;

    assign jump_tgt = jump_pc & 32'hFFFF_FFFC;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;
    logic                    fill_en;

    // pc is unchanged throughout a kept miss, so it indexes both lookup and fill.
    assign idx      = pc_q[IDX_W+1:2];
    assign hit      = valid_q[idx] && (tag_mem[idx] == pc_q[31:IDX_W+2]);
    assign hit_data = data_mem[idx];
    assign fill_en  = rdy && (state_q == WAIT_MEM) && mem_done && !discard_q && !jump_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_mem[idx]  <= pc_q[31:IDX_W+2];
            data_mem[idx] <= mem_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = 32'h0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inst_rdy_d = 1'b0;
        inst_d     = inst_q;
        pc_out_d   = pc_out_q;
        case (state_q)
            IDLE: begin
                if (jump_en) begin
                    pc_d = jump_tgt;
                end else if (!iq_full) begin
                    if (hit) begin
                        inst_rdy_d = 1'b1;
                        inst_d     = hit_data;
                        pc_out_d   = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                    if (discard_q || jump_en) begin
                        if (jump_en) begin
                            pc_d = jump_tgt;
                        end
                    end else begin
                        inst_rdy_d = 1'b1;
                        inst_d     = mem_data;
                        pc_out_d   = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end
                end else if (jump_en) begin
                    // The transfer cannot be aborted; remember to drop its data.
                    pc_d      = jump_tgt;
                    discard_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            inst_rdy_q <= 1'b0;
            inst_q     <= 32'h0;
            pc_out_q   <= 32'h0;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inst_rdy_q <= inst_rdy_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign inst_rdy = inst_rdy_q;
    assign inst     = inst_q;
    assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory handshakes, redirects, back-pressure, chip enable,
// pc wrap, mid-transfer reset and (with ICACHE_EN) cache hits.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        iq_full;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] pc_out;

    int checks   = 0;
    int failures = 0;

    ifetch #(
        .RESET_PC    (32'h0000_0000),
        .ICACHE_LINES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .iq_full (iq_full),
        .jump_en (jump_en),
        .jump_pc (jump_pc),
        .mem_req (mem_req),
        .mem_addr(mem_addr),
        .mem_done(mem_done),
        .mem_data(mem_data),
        .inst_rdy(inst_rdy),
        .inst    (inst),
        .pc_out  (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss path: request appears, memory answers on the following cycle.
    task automatic mem_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        tick();
        check({tag, "_req"}, {31'h0, mem_req}, 32'h1);
        check({tag, "_addr"}, mem_addr, addr);
        mem_done = 1'b1;
        mem_data = data;
        tick();
        mem_done = 1'b0;
        check({tag, "_rdy"}, {31'h0, inst_rdy}, 32'h1);
        check({tag, "_inst"}, inst, data);
        check({tag, "_pc"}, pc_out, addr);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; iq_full = 1'b0; jump_en = 1'b0; jump_pc = 32'h0;
        mem_done = 1'b0; mem_data = 32'h0;
        tick();
        tick();
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_inst_rdy", {31'h0, inst_rdy}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        rst = 1'b0;

        // First fetch: data returned two cycles after the request.
        tick();
        check("f0_req", {31'h0, mem_req}, 32'h1);
        check("f0_addr", mem_addr, 32'h0);
        tick();
        check("f0_req_hold", {31'h0, mem_req}, 32'h1);
        check("f0_rdy_lo", {31'h0, inst_rdy}, 32'h0);
        mem_done = 1'b1; mem_data = 32'h0000_0013;
        tick();
        mem_done = 1'b0;
        check("f0_rdy", {31'h0, inst_rdy}, 32'h1);
        check("f0_inst", inst, 32'h0000_0013);
        check("f0_pc", pc_out, 32'h0);
        check("f0_req_drop", {31'h0, mem_req}, 32'h0);

        mem_fetch("f4", 32'h0000_0004, 32'h0000_0017);

        // Redirect while waiting on 0x8: data dropped, refetch from 0x1000.
        tick();
        check("j_req", {31'h0, mem_req}, 32'h1);
        check("j_addr", mem_addr, 32'h0000_0008);
        jump_en = 1'b1; jump_pc = 32'h0000_1003;
        tick();
        jump_en = 1'b0;
        check("j_addr_hold", mem_addr, 32'h0000_0008);
        check("j_req_hold", {31'h0, mem_req}, 32'h1);
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_done = 1'b0;
        check("j_drop_rdy", {31'h0, inst_rdy}, 32'h0);
        check("j_drop_req", {31'h0, mem_req}, 32'h0);
        mem_fetch("f1000", 32'h0000_1000, 32'h1111_2222);

        // Back-pressure in IDLE for five cycles.
        iq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("full_req", {31'h0, mem_req}, 32'h0);
            check("full_rdy", {31'h0, inst_rdy}, 32'h0);
        end
        iq_full = 1'b0;
        tick();
        check("rel_req", {31'h0, mem_req}, 32'h1);
        check("rel_addr", mem_addr, 32'h0000_1004);

        // Chip enable low with mem_done pending; delivery also ignores iq_full.
        mem_done = 1'b1; mem_data = 32'h0000_0055; rdy = 1'b0; iq_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_req", {31'h0, mem_req}, 32'h1);
            check("frz_rdy", {31'h0, inst_rdy}, 32'h0);
            check("frz_addr", mem_addr, 32'h0000_1004);
        end
        rdy = 1'b1;
        tick();
        mem_done = 1'b0;
        check("frz_done_rdy", {31'h0, inst_rdy}, 32'h1);
        check("frz_done_inst", inst, 32'h0000_0055);
        check("frz_done_pc", pc_out, 32'h0000_1004);
        rdy = 1'b0;
        tick();
        check("frz_hold_pulse", {31'h0, inst_rdy}, 32'h1);
        rdy = 1'b1; iq_full = 1'b0;

        // Jump has priority over issue; then the wrap at the top of memory.
        jump_en = 1'b1; jump_pc = 32'hFFFF_FFFC;
        tick();
        jump_en = 1'b0;
        check("jidle_req", {31'h0, mem_req}, 32'h0);
        check("jidle_rdy", {31'h0, inst_rdy}, 32'h0);
        mem_fetch("ftop", 32'hFFFF_FFFC, 32'h0BAD_F00D);
        tick();
        check("wrap_addr", mem_addr, 32'h0);
        check("wrap_req", {31'h0, mem_req}, 32'h1);

        // Reset mid-transfer; a late mem_done must be ignored.
        rst = 1'b1;
        tick();
        check("mrst_req", {31'h0, mem_req}, 32'h0);
        rst = 1'b0; iq_full = 1'b1; mem_done = 1'b1; mem_data = 32'hFFFF_0000;
        tick();
        mem_done = 1'b0;
        check("late_rdy", {31'h0, inst_rdy}, 32'h0);
        check("late_req", {31'h0, mem_req}, 32'h0);
        iq_full = 1'b0;

        // Loop 0,4,8 then jump back to 0.
        mem_fetch("l0", 32'h0, 32'hA000_0000);
        mem_fetch("l4", 32'h4, 32'hA000_0004);
        mem_fetch("l8", 32'h8, 32'hA000_0008);
        jump_en = 1'b1; jump_pc = 32'h0;
        tick();
        jump_en = 1'b0;
        check("loop_jump_rdy", {31'h0, inst_rdy}, 32'h0);
`ifdef ICACHE_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hit_rdy", {31'h0, inst_rdy}, 32'h1);
            check("hit_req", {31'h0, mem_req}, 32'h0);
            check("hit_pc", pc_out, 32'(4 * i));
            check("hit_inst", inst, 32'hA000_0000 + 32'(4 * i));
        end
        tick();
        check("post_hit_req", {31'h0, mem_req}, 32'h1);
        check("post_hit_addr", mem_addr, 32'h0000_000C);
`else
        mem_fetch("nc0", 32'h0, 32'hB000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
